xoodyak_bist_sequencer: RTL and testbench
=========================================

Name: xoodyak_bist_sequencer

Overview:
- Synthesizable, parametrised self-test sequencer for the Xoodyak hash core (TOP).
- Sweeps the message length over a programmed range. For each length it pulses start, streams a deterministic incrementing byte pattern while honouring the core's busy, collects the digest bytes, and compares them with an expected digest fetched over a request/valid handshake.
- Sits between TOP and a host or JTAG register file; the same function runs on silicon or FPGA.

Parameters:
- LEN_W, 12, width of message-length fields (maximum length 2^LEN_W-1).
- DIGEST_BYTES, 32, digest bytes collected per run.
- SEED, 8'h00, pattern byte for message index 0.
- GAP_CYCLES, 5, idle cycles between runs, before start.
- TIMEOUT, 4096, maximum cycles in LOAD or COLLECT before the run is declared failed.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- go  in  1  one-cycle pulse; begins a sweep; ignored unless idle.
- len_first  in  LEN_W  first message length; sampled on go.
- len_last  in  LEN_W  last message length, inclusive; sampled on go.
- exp_req  out  1  high while waiting for the expected digest of cur_len.
- exp_valid  in  1  expected digest is present; consumed when exp_req && exp_valid.
- exp_digest  in  8*DIGEST_BYTES  expected digest; MSB byte = first digest byte.
- core_start  out  1  one-cycle start pulse to the core.
- core_msg  out  8  message byte to the core.
- core_msg_len  out  LEN_W  current length, held for the whole run.
- core_hash  in  8  digest byte from the core.
- core_valid  in  1  core_hash is valid this cycle.
- core_busy  in  1  core cannot accept a byte.
- busy  out  1  sweep in progress.
- cur_len  out  LEN_W  length under test.
- result_valid  out  1  one-cycle pulse at the end of each run.
- result_match  out  1  run outcome; valid with result_valid.
- obs_digest  out  8*DIGEST_BYTES  last collected digest; held.
- timeout  out  1  sticky; any run timed out.
- fail_count  out  LEN_W  number of failed runs, saturating.
- first_fail_len  out  LEN_W  length of the first failed run; 0 if none.
- done  out  1  high from sweep end until the next go.
- pass  out  1  done && fail_count==0.

Behaviour:
- Reset: every output is 0, state IDLE, and all counters are cleared. This also applies when reset is asserted mid-run; the core is not otherwise notified.
- FSM states: IDLE, EXP, GAP, START, LOAD, COLLECT, CHECK, DONE.
- IDLE/DONE + go → EXP. Sample len_first/len_last; cur_len = len_first; clear fail_count, first_fail_len, timeout, done. If len_first > len_last, go directly to DONE with pass=1.
- EXP: exp_req=1. On exp_valid, latch exp_digest (exp_req drops the next cycle) → GAP.
- GAP: count GAP_CYCLES → START.
- START: core_start=1 for exactly one cycle, with core_msg_len=cur_len. Byte index k=0 → LOAD. If cur_len==0, go directly to COLLECT.
- LOAD:
  - core_msg = (SEED + k) mod 256.
  - On each edge with core_busy==0 the byte is consumed and k increments.
  - After byte cur_len-1 is consumed → COLLECT.
  - core_msg holds its value while core_busy==1.
- COLLECT: on each core_valid, obs shift register ← {obs[8*DIGEST_BYTES-9:0], core_hash}. After DIGEST_BYTES valid bytes → CHECK.
- Byte-count rules: core_valid outside COLLECT is ignored. Extra valid bytes are dropped.
- Timeout: a per-state cycle counter runs in LOAD and COLLECT. Reaching TIMEOUT sets timeout, counts as a mismatch, and goes → CHECK.
- CHECK: result_valid=1 and result_match = (obs==expected && no timeout this run).
  - On mismatch: fail_count++, saturating. If fail_count was 0, first_fail_len=cur_len.
  - If cur_len==len_last → DONE, with done=1 and busy=0. Otherwise cur_len+1 → EXP.
- cur_len wrap: a sweep ends when cur_len equals len_last, so cur_len never wraps.
- busy is 1 in every state except IDLE and DONE.
- go while busy is ignored. go and exp_valid in the same cycle are both handled by their state rules.

Test Plan:
- Sweep 0..0, with the core model returning digest EA152F2B…8BD1 and the matching exp supplied → one core_start, zero bytes, result_match=1, pass=1, fail_count=0.
- Sweep 0..39 with the 40 Xoodyak vectors (len 1 = 27921F8D…30CC, len 39 = D6C825A1…3FC1) → 40 result_valid pulses, all matching, pass=1.
- Len 19 with core_busy asserted 3 cycles out of every 4 → bytes 00..12 are each consumed exactly once, in order, and core_msg is stable while busy.
- Len 5 with exp_digest bit 0 flipped → result_match=0, fail_count=1, first_fail_len=5, pass=0.
- Core never asserts core_valid with TIMEOUT=64 → after 64 cycles in COLLECT: timeout=1, fail counted, and the sweep continues to the next length.
- Reset asserted during LOAD of len 30, then go again with 2..2 → all outputs are 0 after reset, and the new sweep completes normally.

Source files
------------

// File: rtl/xoodyak_bist_sequencer.sv
// Self-test sequencer for the Xoodyak hash core: sweeps message lengths, streams an
// incrementing byte pattern, collects each digest and compares it with a fetched reference.
module xoodyak_bist_sequencer #(
  parameter int unsigned LenW        = 12,
  parameter int unsigned DigestBytes = 32,
  parameter logic [7:0]  Seed        = 8'h00,
  parameter int unsigned GapCycles   = 5,
  parameter int unsigned Timeout     = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     go_i,
  input  logic [LenW-1:0]          len_first_i,
  input  logic [LenW-1:0]          len_last_i,
  output logic                     exp_req_o,
  input  logic                     exp_valid_i,
  input  logic [8*DigestBytes-1:0] exp_digest_i,
  output logic                     core_start_o,
  output logic [7:0]               core_msg_o,
  output logic [LenW-1:0]          core_msg_len_o,
  input  logic [7:0]               core_hash_i,
  input  logic                     core_valid_i,
  input  logic                     core_busy_i,
  output logic                     busy_o,
  output logic [LenW-1:0]          cur_len_o,
  output logic                     result_valid_o,
  output logic                     result_match_o,
  output logic [8*DigestBytes-1:0] obs_digest_o,
  output logic                     timeout_o,
  output logic [LenW-1:0]          fail_count_o,
  output logic [LenW-1:0]          first_fail_len_o,
  output logic                     done_o,
  output logic                     pass_o
);

  localparam int unsigned DigW   = 8 * DigestBytes;
  localparam int unsigned CntMax = (Timeout > GapCycles) ? Timeout : GapCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BcW    = $clog2(DigestBytes + 1);

  localparam logic [CntW-1:0] GapLast = CntW'(GapCycles - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(Timeout - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [BcW-1:0]  BcLast  = BcW'(DigestBytes - 1);
  localparam logic [BcW-1:0]  BcOne   = BcW'(1);
  localparam logic [LenW-1:0] LenOne  = LenW'(1);
  localparam logic [LenW-1:0] FailSat = '1;

  typedef enum logic [2:0] {
    StIdle, StExp, StGap, StStart, StLoad, StCollect, StCheck, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [LenW-1:0]  cur_len_q, cur_len_d;
  logic [LenW-1:0]  len_last_q, len_last_d;
  logic [LenW-1:0]  k_q, k_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BcW-1:0]   bc_q, bc_d;
  logic [DigW-1:0]  exp_q, exp_d;
  logic [DigW-1:0]  obs_q, obs_d;
  logic             run_to_q, run_to_d;
  logic             timeout_q, timeout_d;
  logic [LenW-1:0]  fail_q, fail_d;
  logic [LenW-1:0]  first_fail_q, first_fail_d;
  logic             match;

  assign match = (obs_q == exp_q) && !run_to_q;

  always_comb begin
    state_d      = state_q;
    cur_len_d    = cur_len_q;
    len_last_d   = len_last_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    bc_d         = bc_q;
    exp_d        = exp_q;
    obs_d        = obs_q;
    run_to_d     = run_to_q;
    timeout_d    = timeout_q;
    fail_d       = fail_q;
    first_fail_d = first_fail_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (go_i) begin
          len_last_d   = len_last_i;
          cur_len_d    = len_first_i;
          fail_d       = '0;
          first_fail_d = '0;
          timeout_d    = 1'b0;
          state_d      = (len_first_i > len_last_i) ? StDone : StExp;
        end
      end
      StExp: begin
        if (exp_valid_i) begin
          exp_d   = exp_digest_i;
          cnt_d   = '0;
          state_d = (GapCycles == 0) ? StStart : StGap;
        end
      end
      StGap: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == GapLast) begin
          state_d = StStart;
        end
      end
      StStart: begin
        k_d      = '0;
        cnt_d    = '0;
        bc_d     = '0;
        run_to_d = 1'b0;
        state_d  = (cur_len_q == '0) ? StCollect : StLoad;
      end
      StLoad: begin
        cnt_d = cnt_q + CntOne;
        if (!core_busy_i) begin
          k_d = k_q + LenOne;
        end
        // A byte consumed on the timeout cycle still completes the load.
        if (!core_busy_i && (k_q == cur_len_q - LenOne)) begin
          cnt_d   = '0;
          state_d = StCollect;
        end else if (cnt_q == ToLast) begin
          run_to_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = StCheck;
        end
      end
      StCollect: begin
        cnt_d = cnt_q + CntOne;
        if (core_valid_i) begin
          obs_d = {obs_q[DigW-9:0], core_hash_i};
          bc_d  = bc_q + BcOne;
        end
        if (core_valid_i && (bc_q == BcLast)) begin
          state_d = StCheck;
        end else if (cnt_q == ToLast) begin
          run_to_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = StCheck;
        end
      end
      StCheck: begin
        if (!match) begin
          if (fail_q != FailSat) begin
            fail_d = fail_q + LenOne;
          end
          if (fail_q == '0) begin
            first_fail_d = cur_len_q;
          end
        end
        if (cur_len_q == len_last_q) begin
          state_d = StDone;
        end else begin
          cur_len_d = cur_len_q + LenOne;
          state_d   = StExp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      cur_len_q    <= '0;
      len_last_q   <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      bc_q         <= '0;
      exp_q        <= '0;
      obs_q        <= '0;
      run_to_q     <= 1'b0;
      timeout_q    <= 1'b0;
      fail_q       <= '0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_len_q    <= cur_len_d;
      len_last_q   <= len_last_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      bc_q         <= bc_d;
      exp_q        <= exp_d;
      obs_q        <= obs_d;
      run_to_q     <= run_to_d;
      timeout_q    <= timeout_d;
      fail_q       <= fail_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign exp_req_o        = (state_q == StExp);
  assign core_start_o     = (state_q == StStart);
  assign core_msg_o       = (state_q == StLoad) ? (Seed + k_q[7:0]) : 8'h00;
  assign core_msg_len_o   = cur_len_q;
  assign busy_o           = (state_q != StIdle) && (state_q != StDone);
  assign cur_len_o        = cur_len_q;
  assign result_valid_o   = (state_q == StCheck);
  assign result_match_o   = (state_q == StCheck) && match;
  assign obs_digest_o     = obs_q;
  assign timeout_o        = timeout_q;
  assign fail_count_o     = fail_q;
  assign first_fail_len_o = first_fail_q;
  assign done_o           = (state_q == StDone);
  assign pass_o           = (state_q == StDone) && (fail_q == '0);

endmodule

// File: tb/tb_xoodyak_bist_sequencer.sv
// Directed bench: a behavioural stand-in core with a toy digest, an expected-digest responder,
// and a second instance with a short timeout and a silent core.
module tb_xoodyak_bist_sequencer;

  localparam logic [7:0] Seed = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         go = 1'b0;
  logic [11:0]  len_first = '0, len_last = '0;
  logic         exp_req, exp_valid = 1'b0;
  logic [255:0] exp_digest = '0;
  logic         core_start;
  logic [7:0]   core_msg, core_hash = 8'h00;
  logic [11:0]  core_msg_len;
  logic         core_valid = 1'b0, core_busy = 1'b0;
  logic         busy, result_valid, result_match, timeout, done, pass;
  logic [11:0]  cur_len, fail_count, first_fail_len;
  logic [255:0] obs_digest;

  // Timeout instance: silent core, reference always ready and all zero.
  logic         t_go = 1'b0;
  logic         t_exp_req, t_core_start, t_busy, t_result_valid, t_result_match;
  logic         t_timeout, t_done, t_pass;
  logic [7:0]   t_core_msg;
  logic [11:0]  t_core_msg_len, t_cur_len, t_fail_count, t_first_fail_len;
  logic [255:0] t_obs_digest;

  xoodyak_bist_sequencer dut (
    .clk_i(clk), .reset_i(reset), .go_i(go), .len_first_i(len_first), .len_last_i(len_last),
    .exp_req_o(exp_req), .exp_valid_i(exp_valid), .exp_digest_i(exp_digest),
    .core_start_o(core_start), .core_msg_o(core_msg), .core_msg_len_o(core_msg_len),
    .core_hash_i(core_hash), .core_valid_i(core_valid), .core_busy_i(core_busy),
    .busy_o(busy), .cur_len_o(cur_len), .result_valid_o(result_valid),
    .result_match_o(result_match), .obs_digest_o(obs_digest), .timeout_o(timeout),
    .fail_count_o(fail_count), .first_fail_len_o(first_fail_len), .done_o(done), .pass_o(pass)
  );

  xoodyak_bist_sequencer #(.Timeout(64)) dut_to (
    .clk_i(clk), .reset_i(reset), .go_i(t_go), .len_first_i(12'd1), .len_last_i(12'd2),
    .exp_req_o(t_exp_req), .exp_valid_i(1'b1), .exp_digest_i(256'h0),
    .core_start_o(t_core_start), .core_msg_o(t_core_msg), .core_msg_len_o(t_core_msg_len),
    .core_hash_i(8'h00), .core_valid_i(1'b0), .core_busy_i(1'b0),
    .busy_o(t_busy), .cur_len_o(t_cur_len), .result_valid_o(t_result_valid),
    .result_match_o(t_result_match), .obs_digest_o(t_obs_digest), .timeout_o(t_timeout),
    .fail_count_o(t_fail_count), .first_fail_len_o(t_first_fail_len), .done_o(t_done),
    .pass_o(t_pass)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Toy digest: order-sensitive accumulator spread over 32 bytes, mixed with the length.
  function automatic logic [31:0] acc_step(input logic [31:0] acc, input logic [7:0] b);
    return {acc[26:0], acc[31:27]} ^ {24'h0, b} ^ 32'h9e37_79b9;
  endfunction

  function automatic logic [255:0] mk_digest(input logic [11:0] len, input logic [31:0] acc);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 32; i++) begin
      d[255-8*i -: 8] = acc[8*(i%4) +: 8] ^ 8'(i) ^ len[7:0] ^ {4'h0, len[11:8]};
    end
    return d;
  endfunction

  function automatic logic [255:0] ref_digest(input logic [11:0] len);
    logic [31:0] acc;
    acc = 32'h0;
    for (int k = 0; k < int'(len); k++) acc = acc_step(acc, Seed + 8'(k));
    return mk_digest(len, acc);
  endfunction

  // Stand-in core, acting on the negative edge.
  logic         busy_mode = 1'b0, core_mute = 1'b0;
  int           mode = 0, rx_cnt = 0, tx_cnt = 0, busy_ph = 0;
  logic [11:0]  rx_len = '0;
  logic [31:0]  rx_acc = '0;
  logic [255:0] tx_dig = '0;
  int           n_start = 0, n_bytes = 0;

  always @(negedge clk) begin
    if (reset) begin
      mode = 0; core_valid = 1'b0; core_busy = 1'b0; core_hash = 8'h00;
    end else begin
      core_valid = 1'b0;
      core_busy  = 1'b0;
      if (core_start) begin
        n_start++;
        rx_len = core_msg_len; rx_cnt = 0; rx_acc = '0; busy_ph = 0; tx_cnt = 0;
        tx_dig = mk_digest(core_msg_len, 32'h0);
        mode   = (core_msg_len == 12'd0) ? 2 : 1;
      end else if (mode == 1) begin
        core_busy = busy_mode && (busy_ph % 4 != 3);
        busy_ph++;
        check_eq("msg_byte", core_msg, Seed + 8'(rx_cnt));
        if (!core_busy) begin
          rx_acc = acc_step(rx_acc, core_msg);
          rx_cnt++;
          n_bytes++;
          if (rx_cnt == int'(rx_len)) begin
            mode = 2; tx_cnt = 0; tx_dig = mk_digest(rx_len, rx_acc);
          end
        end
      end else if (mode == 2 && !core_mute) begin
        core_valid = 1'b1;
        core_hash  = tx_dig[255-8*tx_cnt -: 8];
        tx_cnt++;
        if (tx_cnt == 32) mode = 0;
      end
    end
  end

  // Expected-digest responder: answers on the second cycle of each request.
  logic        flip_en = 1'b0;
  logic [11:0] flip_len = '0, exp_len = '0;
  bit          exp_pend = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_valid = 1'b0; exp_pend = 1'b0;
    end else begin
      if (go && !busy) exp_len = len_first;
      if (exp_req) begin
        if (exp_pend) begin
          check_eq("exp_len", cur_len, exp_len);
          exp_valid  = 1'b1;
          exp_digest = ref_digest(exp_len) ^ ((flip_en && exp_len == flip_len) ? 256'h1 : 256'h0);
          exp_len++;
          exp_pend   = 1'b0;
        end else begin
          exp_pend = 1'b1;
        end
      end else begin
        exp_valid = 1'b0;
      end
    end
  end

  int n_res = 0, n_match = 0;
  int t_cyc = 0, t_st = 0, t_lat = -1, t_res = 0, t_match = 0;

  always @(negedge clk) begin
    if (result_valid) begin
      n_res++;
      if (result_match) n_match++;
    end
    t_cyc++;
    if (t_core_start) t_st = t_cyc;
    if (t_result_valid) begin
      if (t_res == 0) t_lat = t_cyc - t_st;
      t_res++;
      if (t_result_match) t_match++;
    end
  end

  int b_res, b_match, b_start, b_bytes;

  task automatic snap();
    b_res = n_res; b_match = n_match; b_start = n_start; b_bytes = n_bytes;
  endtask

  task automatic start_sweep(input logic [11:0] f, input logic [11:0] l);
    @(posedge clk); #1;
    len_first = f; len_last = l; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, done, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_flags"},
             {busy, done, pass, timeout, exp_req, core_start, result_valid, result_match}, '0);
    check_eq({tag, "_lens"}, {cur_len, core_msg_len, fail_count, first_fail_len, core_msg}, '0);
    check_eq({tag, "_obs"}, obs_digest, '0);
  endtask

  task automatic check_run(input string tag, input int res, input int mat, input int st,
                           input int bytes, input logic ps, input logic [11:0] fails);
    check_eq({tag, "_res"}, n_res - b_res, res);
    check_eq({tag, "_match"}, n_match - b_match, mat);
    check_eq({tag, "_starts"}, n_start - b_start, st);
    check_eq({tag, "_bytes"}, n_bytes - b_bytes, bytes);
    check_eq({tag, "_pass"}, pass, ps);
    check_eq({tag, "_fails"}, fail_count, fails);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset");

    // Zero-length run only.
    snap();
    start_sweep(12'd0, 12'd0);
    wait_done("s0_done", 400);
    check_run("s0", 1, 1, 1, 0, 1'b1, 12'd0);
    check_eq("s0_obs", obs_digest, ref_digest(12'd0));
    check_eq("s0_busy", busy, 1'b0);

    // Full sweep 0..39, with a stray go mid-sweep that must be ignored.
    snap();
    start_sweep(12'd0, 12'd39);
    repeat (100) @(posedge clk);
    start_sweep(12'd5, 12'd5);
    wait_done("s39_done", 6000);
    check_run("s39", 40, 40, 40, 780, 1'b1, 12'd0);
    check_eq("s39_cur_len", cur_len, 12'd39);
    check_eq("s39_obs", obs_digest, ref_digest(12'd39));
    check_eq("s39_timeout", timeout, 1'b0);

    // Length 19 with the core busy three cycles in four.
    busy_mode = 1'b1;
    snap();
    start_sweep(12'd19, 12'd19);
    wait_done("b19_done", 1000);
    check_run("b19", 1, 1, 1, 19, 1'b1, 12'd0);
    busy_mode = 1'b0;

    // Corrupted reference at length 5 inside a 4..6 sweep.
    flip_en = 1'b1; flip_len = 12'd5;
    snap();
    start_sweep(12'd4, 12'd6);
    wait_done("f5_done", 1000);
    check_run("f5", 3, 2, 3, 15, 1'b0, 12'd1);
    check_eq("f5_first_fail", first_fail_len, 12'd5);
    flip_en = 1'b0;

    // Empty range: straight to done, previous failures cleared.
    snap();
    start_sweep(12'd7, 12'd3);
    wait_done("empty_done", 10);
    check_run("empty", 0, 0, 0, 0, 1'b1, 12'd0);
    check_eq("empty_first_fail", first_fail_len, 12'd0);

    // Reset in the middle of loading length 30, then a clean 2..2 sweep.
    snap();
    start_sweep(12'd30, 12'd30);
    for (int n = 0; n < 200 && (n_bytes - b_bytes) < 10; n++) begin
      @(posedge clk); #1;
    end
    check_eq("mid_in_load", {busy, 8'(n_bytes - b_bytes >= 10)}, {1'b1, 8'd1});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_idle("midrst");
    snap();
    start_sweep(12'd2, 12'd2);
    wait_done("r2_done", 400);
    check_run("r2", 1, 1, 1, 2, 1'b1, 12'd0);
    check_eq("r2_obs", obs_digest, ref_digest(12'd2));

    // Silent core against Timeout=64: both lengths time out, sweep still finishes.
    @(posedge clk); #1;
    t_go = 1'b1;
    @(posedge clk); #1;
    t_go = 1'b0;
    for (int n = 0; n < 1000 && !t_done; n++) begin
      @(posedge clk); #1;
    end
    check_eq("to_done", t_done, 1'b1);
    check_eq("to_timeout", t_timeout, 1'b1);
    check_eq("to_fails", t_fail_count, 12'd2);
    check_eq("to_first_fail", t_first_fail_len, 12'd1);
    check_eq("to_results", {16'(t_res), 16'(t_match)}, {16'd2, 16'd0});
    check_eq("to_latency", t_lat, 66);
    check_eq("to_pass", t_pass, 1'b0);
    check_eq("to_cur_len", t_cur_len, 12'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

endmodule
